// File: rtl/wormhole_arb_pkg.sv
// Shared types and constants for the wormhole round-robin arbiter family.
// The arbiter state struct is sized for the widest supported port count (16).
package wormhole_arb_pkg;

    localparam int ARB_IDX_MAX_W       = 4;
    localparam int WDOG_CYCLES_DEFAULT = 256;

    function automatic int arb_idx_width(input int num_ports);
        return (num_ports <= 2) ? 1 : $clog2(num_ports);
    endfunction

    typedef struct packed {
        logic                     locked;
        logic [ARB_IDX_MAX_W-1:0] owner;
        logic [ARB_IDX_MAX_W-1:0] rr_ptr;
    } arb_state_t;

    localparam int ARB_STATE_W = $bits(arb_state_t);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit at or above rr_ptr_i,
// wrapping explicitly at NUM_PORTS so non-power-of-two port counts work.
module rr_pick
    import wormhole_arb_pkg::*;
#(
    parameter int NUM_PORTS = 5,
    parameter int IDX_W     = arb_idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] request_i,
    input  logic [IDX_W-1:0]     rr_ptr_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [IDX_W-1:0]     idx_o
);

    localparam int PW = IDX_W + 1;

    logic [PW-1:0] pos;
    logic          found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            pos = {1'b0, rr_ptr_i} + PW'(k);
            if (pos >= PW'(NUM_PORTS)) begin
                pos = pos - PW'(NUM_PORTS);
            end
            if (!found && request_i[pos[IDX_W-1:0]]) begin
                found                     = 1'b1;
                grant_o[pos[IDX_W-1:0]]   = 1'b1;
                idx_o                     = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/wormhole_rr_arbiter.sv
// N-input wormhole round-robin arbiter: grant locks from head to tail flit and
// holds through owner bubbles. Optional lock watchdog: WORMHOLE_RR_ARBITER_WATCHDOG_EN.
module wormhole_rr_arbiter
    import wormhole_arb_pkg::*;
#(
    parameter int NUM_PORTS   = 5,
    parameter int WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS-1:0]                request,
    input  logic                                forwarding_head,
    input  logic                                forwarding_tail,
    output logic [NUM_PORTS-1:0]                grant,
    output logic                                grant_valid,
    output logic [arb_idx_width(NUM_PORTS)-1:0] grant_idx,
    output logic                                locked,
    output logic                                wdog_error,
    output logic [ARB_STATE_W-1:0]              dbg_state_o
);

    localparam int IDX_W = arb_idx_width(NUM_PORTS);

    if (NUM_PORTS < 2 || NUM_PORTS > 16 || WDOG_CYCLES < 2) begin : g_bad_param
        $error("wormhole_rr_arbiter: unsupported NUM_PORTS or WDOG_CYCLES");
    end

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     owner, rr_ptr, pick_idx;
    logic [NUM_PORTS-1:0] pick_grant, owner_oh;
    logic                 head_ok, tail_ok;

    assign owner  = state_q.owner[IDX_W-1:0];
    assign rr_ptr = state_q.rr_ptr[IDX_W-1:0];

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_pick (
        .request_i (request),
        .rr_ptr_i  (rr_ptr),
        .grant_o   (pick_grant),
        .idx_o     (pick_idx)
    );

    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
    end

    // While locked only the owner can be granted; its dropped request is a bubble.
    always_comb begin
        if (state_q.locked) begin
            grant_valid = request[owner];
            grant       = owner_oh & request;
            grant_idx   = request[owner] ? owner : '0;
        end else begin
            grant_valid = |request;
            grant       = pick_grant;
            grant_idx   = pick_idx;
        end
    end

    assign head_ok = forwarding_head & grant_valid;
    assign tail_ok = forwarding_tail & grant_valid;

    always_comb begin
        state_d = state_q;
        if (!state_q.locked) begin
            if (head_ok) begin
                state_d.owner  = ARB_IDX_MAX_W'(grant_idx);
                state_d.rr_ptr = (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0
                                 : ARB_IDX_MAX_W'(grant_idx + IDX_W'(1));
                state_d.locked = ~tail_ok;
            end
        end else if (tail_ok && !head_ok) begin
            state_d.locked = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign locked      = state_q.locked;
    assign dbg_state_o = state_q;

`ifdef WORMHOLE_RR_ARBITER_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES) + 1;

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_error_q, wdog_error_d;
    logic              wdog_hit;

    // Counter saturates at the limit; the error is sticky and the lock is never broken.
    assign wdog_hit = state_q.locked && (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));

    always_comb begin
        wdog_error_d = wdog_error_q | wdog_hit;
        if (!state_q.locked) begin
            wdog_cnt_d = '0;
        end else if (wdog_hit) begin
            wdog_cnt_d = wdog_cnt_q;
        end else begin
            wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_cnt_q   <= '0;
            wdog_error_q <= 1'b0;
        end else begin
            wdog_cnt_q   <= wdog_cnt_d;
            wdog_error_q <= wdog_error_d;
        end
    end

    assign wdog_error = wdog_error_q;
`else
    assign wdog_error = 1'b0;
`endif

`ifndef SYNTHESIS
    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(grant));
    a_grant_subset: assert property (@(posedge clk) disable iff (!rst)
        (grant & ~request) == '0);
    a_rr_stable_locked: assert property (@(posedge clk) disable iff (!rst)
        state_q.locked |=> $stable(state_q.rr_ptr));
    a_no_head_locked: assert property (@(posedge clk) disable iff (!rst)
        !(state_q.locked && head_ok));
`endif

endmodule

// File: tb/tb_wormhole_rr_arbiter.sv
// Directed + random bench for wormhole_rr_arbiter against a behavioural packet-level model.
// Build with WORMHOLE_RR_ARBITER_WATCHDOG_EN defined to exercise the lock watchdog.
module tb_wormhole_rr_arbiter;

    localparam int N  = 5;
    localparam int WD = 8;

`ifdef WORMHOLE_RR_ARBITER_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] request;
    logic         fh, ft;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [2:0]   grant_idx;
    logic         locked;
    logic         wdog_error;
    logic [8:0]   dbg_state;

    always #5 clk = ~clk;

    wormhole_rr_arbiter #(
        .NUM_PORTS   (N),
        .WDOG_CYCLES (WD)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .request         (request),
        .forwarding_head (fh),
        .forwarding_tail (ft),
        .grant           (grant),
        .grant_valid     (grant_valid),
        .grant_idx       (grant_idx),
        .locked          (locked),
        .wdog_error      (wdog_error),
        .dbg_state_o     (dbg_state)
    );

    int checks   = 0;
    int failures = 0;

    // Packet-level model: who owns the output, who is next in line, how long locked.
    bit           m_locked;
    int           m_owner, m_ptr, m_run;
    bit           m_werr;
    logic [N-1:0] e_grant;
    bit           e_gv;
    int           e_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_ptr = 0; m_run = 0; m_werr = 0;
    endtask

    task automatic compute_expected();
        e_grant = '0; e_gv = 0; e_idx = 0;
        if (m_locked) begin
            if (request[m_owner]) begin
                e_gv = 1; e_grant[m_owner] = 1'b1; e_idx = m_owner;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_ptr + k) % N;
                if (!e_gv && request[p]) begin
                    e_gv = 1; e_grant[p] = 1'b1; e_idx = p;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        compute_expected();
        check($sformatf("%s.grant", tag), 32'(grant), 32'(e_grant));
        check($sformatf("%s.gv", tag), 32'(grant_valid), 32'(e_gv));
        check($sformatf("%s.idx", tag), 32'(grant_idx), e_idx);
        check($sformatf("%s.locked", tag), 32'(locked), 32'(m_locked));
        check($sformatf("%s.wdog", tag), 32'(wdog_error), 32'(m_werr & WD_EN));
        check($sformatf("%s.state", tag), 32'(dbg_state),
              32'({m_locked, 4'(m_owner), 4'(m_ptr)}));
    endtask

    task automatic model_step(input bit head, input bit tail);
        bit hq, tq;
        hq = head && e_gv;
        tq = tail && e_gv;
        if (m_locked) begin
            m_run++;
            if (m_run >= WD) m_werr = 1;
        end else begin
            m_run = 0;
        end
        if (!m_locked) begin
            if (hq) begin
                m_owner  = e_idx;
                m_ptr    = (e_idx + 1) % N;
                m_locked = !tq;
            end
        end else if (tq && !hq) begin
            m_locked = 0;
        end
    endtask

    // Called at a falling edge: drive, check combinational outputs, clock, advance model.
    task automatic cycle(input logic [N-1:0] req, input bit head, input bit tail, input string tag);
        request = req; fh = head; ft = tail;
        #1;
        check_outputs(tag);
        @(posedge clk);
        model_step(head, tail);
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] r;
        bit           h, t;

        rst = 1'b0; request = '0; fh = 1'b0; ft = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        request = 5'b10110;
        #1;
        check_outputs("rst_follow");
        check("rst_grant", 32'(grant), 32'h02);
        @(negedge clk);
        rst = 1'b1;

        // Single-flit packet moves priority past the winner.
        cycle(5'b10110, 1, 1, "t1_single");
        cycle(5'b10110, 0, 0, "t1_next");
        check("t1_grant", 32'(grant), 32'h04);

        // Lock on input 4, owner bubbles with ignored tail, then real tail.
        cycle(5'b10000, 1, 0, "t2_head4");
        cycle(5'b01111, 0, 0, "t2_bubble0");
        cycle(5'b01111, 0, 1, "t2_bubble1");
        cycle(5'b01111, 0, 0, "t2_bubble2");
        check("t2_bubble_locked", 32'(locked), 32'h1);
        cycle(5'b11111, 0, 1, "t2_tail");
        cycle(5'b11111, 0, 0, "t2_after");
        check("t2_after_grant", 32'(grant), 32'h01);

        // Fairness: everyone requests, single-flit packets rotate through all inputs.
        for (int i = 0; i < 6; i++) begin
            request = 5'b11111;
            #1;
            check($sformatf("fair%0d", i), 32'(grant_idx), i % N);
            cycle(5'b11111, 1, 1, "fair");
        end

        // Unqualified-by-lock tail does nothing.
        cycle(5'b00001, 0, 1, "t4_tail_unlocked");
        cycle(5'b00001, 0, 0, "t4_after");

        // Back-to-back multi-flit packets with no idle cycle.
        cycle(5'b00110, 1, 0, "t5_head1");
        cycle(5'b00110, 0, 0, "t5_body");
        cycle(5'b00110, 0, 1, "t5_tail1");
        cycle(5'b00110, 1, 0, "t5_head2");
        cycle(5'b00100, 0, 1, "t5_tail2");

        // Long lock for the watchdog.
        cycle(5'b01000, 1, 0, "t6_head3");
        for (int i = 0; i < 10; i++) cycle(5'b01000, 0, 0, "t6_hold");
        cycle(5'b01000, 0, 1, "t6_tail");
        cycle(5'b00000, 0, 0, "t6_idle");
        check("t6_wdog_sticky", 32'(wdog_error), 32'(WD_EN));

        // Asynchronous reset while locked on input 2.
        cycle(5'b00100, 1, 0, "t7_head2");
        check("t7_locked_before", 32'(locked), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("t7_locked_async", 32'(locked), 32'h0);
        model_reset();
        check_outputs("t7_in_reset");
        @(negedge clk);
        rst = 1'b1;
        cycle(5'b00100, 0, 0, "t7_after");
        check("t7_after_grant", 32'(grant), 32'h04);

        // Random traffic; head only offered while the model is unlocked.
        for (int i = 0; i < 400; i++) begin
            r = N'($urandom_range(0, (1 << N) - 1));
            if (m_locked && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
            h = !m_locked && ($urandom_range(0, 1) == 1);
            t = ($urandom_range(0, 2) == 0);
            cycle(r, h, t, "rnd");
        end
        cycle(5'b00000, 0, 0, "final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
